// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF/D memory port arbiter: default widths,
// starvation limit and the encoding of the outstanding-read owner.
package mem_port_arbiter_pkg;

    localparam int DEF_ADDR_W   = 16;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_MAX_WAIT = 4;
    localparam int WAIT_CNT_W   = 4;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF   = 2'd1;
    localparam logic [1:0] OWN_D    = 2'd2;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, the load/store port and the unified memory port.
// The core/memory side uses master, the arbiter uses slave.
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              starve;

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, starve
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, starve
    );

endinterface

// File: rtl/arb_wait_counter.sv
// Saturating count of consecutive cycles the fetch port was denied;
// limit flags that the fetch port must win the next conflict.
module arb_wait_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic limit
);

    localparam logic [WAIT_CNT_W-1:0] MAX_CNT = WAIT_CNT_W'(MAX_WAIT);

    logic [WAIT_CNT_W-1:0] cnt_r;

    // Clear wins over increment; increment holds at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {WAIT_CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {WAIT_CNT_W{1'b0}};
        end else if (inc && (cnt_r != MAX_CNT)) begin
            cnt_r <= cnt_r + {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign limit = (cnt_r == MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and
// load/store: grants one requester per cycle and routes read data back.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    logic       if_gnt_s;
    logic       d_gnt_s;
    logic       starve_s;
    logic       wait_inc_s;
    logic       wait_clr_s;
    logic [1:0] rsp_owner_s;
    logic [1:0] rsp_owner_r;

    // Grant: D wins a conflict unless the fetch port has waited MAX_WAIT cycles.
    always_comb begin
        if_gnt_s = 1'b0;
        d_gnt_s  = 1'b0;
        if (rst) begin
            if_gnt_s = 1'b0;
            d_gnt_s  = 1'b0;
        end else if (bus.if_req && bus.d_req) begin
            if (starve_s) begin
                if_gnt_s = 1'b1;
            end else begin
                d_gnt_s = 1'b1;
            end
        end else if (bus.if_req) begin
            if_gnt_s = 1'b1;
        end else if (bus.d_req) begin
            d_gnt_s = 1'b1;
        end else begin
            if_gnt_s = 1'b0;
            d_gnt_s  = 1'b0;
        end
    end

    assign wait_inc_s = bus.if_req & ~if_gnt_s;
    assign wait_clr_s = ~wait_inc_s;

    arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (wait_clr_s),
        .inc   (wait_inc_s),
        .limit (starve_s)
    );

    // Memory port mux from the winning requester; idle port drives zeros.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = {ADDR_W{1'b0}};
        bus.mem_wdata = {DATA_W{1'b0}};
        case ({if_gnt_s, d_gnt_s})
            2'b10: begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = bus.if_addr;
            end
            2'b01: begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = bus.d_we;
                bus.mem_addr  = bus.d_addr;
                bus.mem_wdata = bus.d_wdata;
            end
            default: begin
                bus.mem_en    = 1'b0;
                bus.mem_we    = 1'b0;
                bus.mem_addr  = {ADDR_W{1'b0}};
                bus.mem_wdata = {DATA_W{1'b0}};
            end
        endcase
    end

    // Owner of the read issued this cycle; stores leave no response pending.
    always_comb begin
        rsp_owner_s = OWN_NONE;
        if (if_gnt_s) begin
            rsp_owner_s = OWN_IF;
        end else if (d_gnt_s && !bus.d_we) begin
            rsp_owner_s = OWN_D;
        end else begin
            rsp_owner_s = OWN_NONE;
        end
    end

    // Response owner register, cleared so a read in flight at reset is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_owner_r <= OWN_NONE;
        end else begin
            rsp_owner_r <= rsp_owner_s;
        end
    end

    assign bus.if_gnt    = if_gnt_s;
    assign bus.d_gnt     = d_gnt_s;
    assign bus.starve    = starve_s & ~rst;
    assign bus.if_rvalid = (rsp_owner_r == OWN_IF) & ~rst;
    assign bus.d_rvalid  = (rsp_owner_r == OWN_D) & ~rst;
    assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : {DATA_W{1'b0}};
    assign bus.d_rdata   = bus.d_rvalid ? bus.mem_rdata : {DATA_W{1'b0}};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a reference arbiter model checks every
// cycle, and expected read data queued at grant is popped when rvalid appears.
module tb_mem_port_arbiter;

    localparam int MAX_WAIT = 4;
    localparam int M_NONE   = 0;
    localparam int M_IF     = 1;
    localparam int M_D      = 2;

    logic clk;
    logic rst;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .ADDR_W   (16),
        .DATA_W   (16),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Memory under the arbiter and the bench's own reference copy
    logic [15:0] mem     [256];
    logic [15:0] ref_mem [256];

    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) begin
            mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
        end
        if (bus.mem_en && !bus.mem_we) begin
            bus.mem_rdata <= mem[bus.mem_addr[7:0]];
        end
    end

    // Reference model state and scoreboard
    int          m_wait = 0;
    int          m_pend = M_NONE;
    logic [15:0] if_q[$];
    logic [15:0] d_q[$];
    logic [15:0] last_if_rdata = 16'h0000;
    logic        log_en = 1'b0;
    logic [1:0]  gnt_log[$];
    logic        starve_log[$];

    logic        eg_if, eg_d;
    logic [15:0] e_addr, e_wdata, e_dat;

    always @(negedge clk) begin
        eg_if = 1'b0;
        eg_d  = 1'b0;
        if (!rst) begin
            if (bus.if_req && bus.d_req) begin
                if (m_wait == MAX_WAIT) eg_if = 1'b1;
                else                    eg_d  = 1'b1;
            end else if (bus.if_req) begin
                eg_if = 1'b1;
            end else if (bus.d_req) begin
                eg_d = 1'b1;
            end
        end
        e_addr  = eg_if ? bus.if_addr : (eg_d ? bus.d_addr : 16'h0000);
        e_wdata = eg_d ? bus.d_wdata : 16'h0000;

        check_val("if_gnt",    32'(bus.if_gnt),    32'(eg_if));
        check_val("d_gnt",     32'(bus.d_gnt),     32'(eg_d));
        check_val("mem_en",    32'(bus.mem_en),    32'(eg_if | eg_d));
        check_val("mem_we",    32'(bus.mem_we),    32'(eg_d & bus.d_we));
        check_val("mem_addr",  32'(bus.mem_addr),  32'(e_addr));
        check_val("mem_wdata", 32'(bus.mem_wdata), 32'(e_wdata));
        check_val("starve",    32'(bus.starve),    32'((m_wait == MAX_WAIT) && !rst));

        if (!rst && m_pend == M_IF && if_q.size() > 0) begin
            e_dat = if_q.pop_front();
            check_val("if_rvalid", 32'(bus.if_rvalid), 32'd1);
            check_val("if_rdata",  32'(bus.if_rdata),  32'(e_dat));
            last_if_rdata = bus.if_rdata;
        end else begin
            check_val("if_rvalid_idle", 32'(bus.if_rvalid), 32'd0);
            check_val("if_rdata_idle",  32'(bus.if_rdata),  32'd0);
        end
        if (!rst && m_pend == M_D && d_q.size() > 0) begin
            e_dat = d_q.pop_front();
            check_val("d_rvalid", 32'(bus.d_rvalid), 32'd1);
            check_val("d_rdata",  32'(bus.d_rdata),  32'(e_dat));
        end else begin
            check_val("d_rvalid_idle", 32'(bus.d_rvalid), 32'd0);
            check_val("d_rdata_idle",  32'(bus.d_rdata),  32'd0);
        end

        if (log_en) begin
            gnt_log.push_back({bus.if_gnt, bus.d_gnt});
            starve_log.push_back(bus.starve);
        end

        if (rst) begin
            m_wait = 0;
            m_pend = M_NONE;
            if_q.delete();
            d_q.delete();
        end else begin
            m_pend = eg_if ? M_IF : ((eg_d && !bus.d_we) ? M_D : M_NONE);
            if (eg_if) if_q.push_back(ref_mem[bus.if_addr[7:0]]);
            if (eg_d && !bus.d_we) d_q.push_back(ref_mem[bus.d_addr[7:0]]);
            if (eg_d && bus.d_we) ref_mem[bus.d_addr[7:0]] = bus.d_wdata;
            if (bus.if_req && !eg_if) m_wait = (m_wait == MAX_WAIT) ? MAX_WAIT : m_wait + 1;
            else                      m_wait = 0;
        end
    end

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic ir, input logic [15:0] ia,
                         input logic dr, input logic dw, input logic [15:0] da, input logic [15:0] dd);
        bus.if_req  = ir;
        bus.if_addr = ia;
        bus.d_req   = dr;
        bus.d_we    = dw;
        bus.d_addr  = da;
        bus.d_wdata = dd;
    endtask

    logic [1:0] exp_seq [6];

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 16'(i * 257) ^ 16'h5A00;
            ref_mem[i] = 16'(i * 257) ^ 16'h5A00;
        end
        exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
        rst = 1'b1;
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        step(3);
        rst = 1'b0;
        step(1);

        // 1: fetch only, three back-to-back reads
        drive(1'b1, 16'h0004, 1'b0, 1'b0, 16'h0000, 16'h0000);
        step(3);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        step(2);

        // 2: conflict, D load wins, IF then served
        drive(1'b1, 16'h0008, 1'b1, 1'b0, 16'h0010, 16'h0000);
        step(1);
        drive(1'b1, 16'h0008, 1'b0, 1'b0, 16'h0000, 16'h0000);
        step(1);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        step(2);

        // 3: store then fetch of the stored word
        drive(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0020, 16'hBEEF);
        step(1);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        step(1);
        drive(1'b1, 16'h0020, 1'b0, 1'b0, 16'h0000, 16'h0000);
        step(1);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        step(2);
        check_val("store_readback", 32'(last_if_rdata), 32'h0000BEEF);

        // 4: starvation, both held six cycles
        drive(1'b1, 16'h0040, 1'b1, 1'b0, 16'h0030, 16'h0000);
        log_en = 1'b1;
        step(6);
        log_en = 1'b0;
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        step(2);
        check_val("starve_log_len", 32'(gnt_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < gnt_log.size(); i++) begin
            check_val($sformatf("starve_seq%0d", i), 32'(gnt_log[i]), 32'(exp_seq[i]));
            check_val($sformatf("starve_flag%0d", i), 32'(starve_log[i]), 32'(i == 4));
        end

        // 5a: reset after a granted load with wait count built up
        drive(1'b1, 16'h0041, 1'b1, 1'b0, 16'h0031, 16'h0000);
        step(3);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(6);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        step(2);

        // 5b: reset right after a fetch grant
        drive(1'b1, 16'h0007, 1'b0, 1'b0, 16'h0000, 16'h0000);
        step(1);
        rst = 1'b1;
        step(1);
        check_val("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
        check_val("rst_if_gnt",    32'(bus.if_gnt),    32'd0);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        step(1);
        rst = 1'b0;
        step(2);

        // 6: idle
        step(10);
        check_val("idle_mem_en", 32'(bus.mem_en), 32'd0);
        check_val("idle_starve", 32'(bus.starve), 32'd0);
        check_val("if_q_empty",  32'(if_q.size()), 32'd0);
        check_val("d_q_empty",   32'(d_q.size()),  32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
